bpu_group_p: RTL and testbench

BPU_GROUP_P -- requirements
Module: bpu_group_p

---
 rtl/bpu_group_p.sv | 168 ++++++++++++++++
 tb/tb_bpu_group_p.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_group_p.sv
// Binary (XNOR/popcount) convolution group: a shared K-row image window scored against
// NCH weight kernels, one kernel row per cycle, into saturating signed accumulators.
module bpu_group_p #(
    parameter int unsigned NCH  = 8,
    parameter int unsigned K    = 7,
    parameter int unsigned ACCW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [K:0]              data_in,
    input  logic                    img_shift,
    input  logic                    img_up,
    input  logic                    wgt_we,
    input  logic [$clog2(NCH)-1:0]  wgt_ch,
    input  logic [$clog2(K)-1:0]    wgt_row,
    input  logic                    start,
    input  logic [$clog2(K):0]      cfg_rows,
    input  logic                    win_sel,
    output logic                    busy,
    output logic                    out_valid,
    output logic [NCH*ACCW-1:0]     acc_out
);

    localparam int unsigned RW   = $clog2(K);
    localparam int unsigned RCW  = RW + 1;
    localparam int unsigned SUMW = ACCW + RW + 2;

    localparam logic signed [SUMW-1:0] SatMax = SUMW'(2 ** (ACCW - 1) - 1);
    localparam logic signed [SUMW-1:0] SatMin = -SatMax;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                 state_q, state_d;
    logic [K:0]             img_q [K];
    logic [K:0]             img_d [K];
    logic [K-1:0]           wgt_q [NCH][K];
    logic [K-1:0]           wgt_d [NCH][K];
    logic signed [ACCW-1:0] acc_q [NCH];
    logic signed [ACCW-1:0] acc_d [NCH];
    logic [RCW-1:0]         rows_q, rows_d;
    logic [RW-1:0]          idx_q, idx_d;
    logic                   win_q, win_d;
    logic                   acc_clr;
    logic                   acc_en;
    logic [K-1:0]           win_bits;

    // One row step: agreement count m gives a contribution of 2m - K, clamped symmetrically.
    function automatic logic signed [ACCW-1:0] acc_step(
        input logic signed [ACCW-1:0] acc,
        input logic [K-1:0]           win,
        input logic [K-1:0]           wgt
    );
        logic [K-1:0]           agree;
        int unsigned            m;
        logic signed [SUMW-1:0] sum;
        agree = ~(win ^ wgt);
        m = 0;
        for (int unsigned b = 0; b < K; b++) begin
            m += 32'(agree[b]);
        end
        sum = SUMW'(acc) + $signed(SUMW'(2 * m)) - $signed(SUMW'(K));
        if (sum > SatMax) begin
            sum = SatMax;
        end else if (sum < SatMin) begin
            sum = SatMin;
        end
        return sum[ACCW-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        idx_d   = idx_q;
        win_d   = win_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCalc;
                    rows_d  = (cfg_rows == '0 || cfg_rows > RCW'(K)) ? RCW'(K) : cfg_rows;
                    win_d   = win_sel;
                    idx_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            StCalc: begin
                acc_en = 1'b1;
                if ({1'b0, idx_q} + RCW'(1) == rows_q) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + RW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Image and weight stores are only writable while idle.
    always_comb begin
        img_d = img_q;
        wgt_d = wgt_q;
        if (state_q == StIdle) begin
            if (img_shift) begin
                for (int unsigned r = 0; r < K; r++) begin
                    img_d[r] = {img_q[r][K-1:0], data_in[r]};
                end
            end else if (img_up) begin
                for (int unsigned r = 1; r < K; r++) begin
                    img_d[r] = img_q[r-1];
                end
                img_d[0] = '0;
            end
            if (wgt_we && 32'(wgt_ch) < NCH && 32'(wgt_row) < K) begin
                wgt_d[wgt_ch][wgt_row] = data_in[K-1:0];
            end
        end
    end

    always_comb begin
        acc_d    = acc_q;
        win_bits = win_q ? img_q[idx_q][K:1] : img_q[idx_q][K-1:0];
        for (int unsigned c = 0; c < NCH; c++) begin
            if (acc_clr) begin
                acc_d[c] = '0;
            end else if (acc_en) begin
                acc_d[c] = acc_step(acc_q[c], win_bits, wgt_q[c][idx_q]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            img_q   <= '{default: '0};
            wgt_q   <= '{default: '{default: '0}};
            acc_q   <= '{default: '0};
            rows_q  <= '0;
            idx_q   <= '0;
            win_q   <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            img_q   <= img_d;
            wgt_q   <= wgt_d;
            acc_q   <= acc_d;
            rows_q  <= rows_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);

    always_comb begin
        acc_out = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            acc_out[c*ACCW +: ACCW] = acc_q[c];
        end
    end

endmodule

// File: tb/tb_bpu_group_p.sv
// Randomised scoreboard bench for bpu_group_p: an ACCW=8 and an ACCW=6 instance share stimulus
// and are checked against an arithmetic reference model of the image/weight stores.
module tb_bpu_group_p;

    localparam int K   = 7;
    localparam int NCH = 8;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  data_in;
    logic        img_shift;
    logic        img_up;
    logic        wgt_we;
    logic [2:0]  wgt_ch;
    logic [2:0]  wgt_row;
    logic        start;
    logic [3:0]  cfg_rows;
    logic        win_sel;
    logic        busy8, ov8, busy6, ov6;
    logic [63:0] acc8;
    logic [47:0] acc6;

    bpu_group_p #(.NCH(8), .K(7), .ACCW(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data_in   (data_in),
        .img_shift (img_shift),
        .img_up    (img_up),
        .wgt_we    (wgt_we),
        .wgt_ch    (wgt_ch),
        .wgt_row   (wgt_row),
        .start     (start),
        .cfg_rows  (cfg_rows),
        .win_sel   (win_sel),
        .busy      (busy8),
        .out_valid (ov8),
        .acc_out   (acc8)
    );

    bpu_group_p #(.NCH(8), .K(7), .ACCW(6)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data_in   (data_in),
        .img_shift (img_shift),
        .img_up    (img_up),
        .wgt_we    (wgt_we),
        .wgt_ch    (wgt_ch),
        .wgt_row   (wgt_row),
        .start     (start),
        .cfg_rows  (cfg_rows),
        .win_sel   (win_sel),
        .busy      (busy6),
        .out_valid (ov6),
        .acc_out   (acc6)
    );

    typedef struct packed {
        logic [31:0] due;
        logic [63:0] e8;
        logic [47:0] e6;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] img_m [K];
    logic [6:0] wgt_m [NCH][K];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < K; r++) begin
            img_m[r] = '0;
            for (int c = 0; c < NCH; c++) wgt_m[c][r] = '0;
        end
    endtask

    // Score = sum over rows of (2*agreements - K), clamped to +-(2^(accw-1)-1) after each row.
    function automatic int model_acc(int r, bit ws, int c, int accw);
        int         lim, acc, m;
        logic [6:0] win, agree;
        lim = (1 << (accw - 1)) - 1;
        acc = 0;
        for (int i = 0; i < r; i++) begin
            win   = ws ? img_m[i][7:1] : img_m[i][6:0];
            agree = ~(win ^ wgt_m[c][i]);
            m     = $countones(agree);
            acc   = acc + 2 * m - K;
            if (acc > lim) acc = lim;
            if (acc < -lim) acc = -lim;
        end
        return acc;
    endfunction

    task automatic img_op(input bit sh, input bit up, input logic [7:0] d);
        img_shift = sh;
        img_up    = up;
        data_in   = d;
        tick();
        img_shift = 1'b0;
        img_up    = 1'b0;
        if (sh) begin
            for (int r = 0; r < K; r++) img_m[r] = {img_m[r][6:0], d[r]};
        end else if (up) begin
            for (int r = K - 1; r > 0; r--) img_m[r] = img_m[r-1];
            img_m[0] = '0;
        end
    endtask

    task automatic wr(input logic [2:0] ch, input logic [2:0] row, input logic [6:0] d);
        wgt_we  = 1'b1;
        wgt_ch  = ch;
        wgt_row = row;
        data_in = {1'($urandom), d};
        tick();
        wgt_we = 1'b0;
        if (row < 3'(K)) wgt_m[ch][row] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    // Runs one convolution; optionally stalls enable mid-CALC and drives ignored traffic while busy.
    task automatic run_conv(input int cfg, input bit ws, input int stall, input bit junk);
        int   r, cnt;
        exp_t e;
        r = (cfg == 0 || cfg > K) ? K : cfg;
        e.due = 32'(cyc + 1 + r + stall);
        for (int c = 0; c < NCH; c++) begin
            e.e8[c*8 +: 8] = 8'(model_acc(r, ws, c, 8));
            e.e6[c*6 +: 6] = 6'(model_acc(r, ws, c, 6));
        end
        exp_q.push_back(e);
        start    = 1'b1;
        cfg_rows = 4'(cfg);
        win_sel  = ws;
        tick();
        start = 1'b0;
        cnt   = 0;
        for (int guard = 0; guard < 64 && busy8 === 1'b1; guard++) begin
            cnt++;
            enable = !(stall > 0 && cnt >= 2 && cnt < 2 + stall);
            if (junk) begin
                start     = 1'b1;
                wgt_we    = 1'b1;
                img_shift = 1'b1;
                img_up    = 1'($urandom);
                data_in   = 8'($urandom);
                wgt_ch    = 3'($urandom);
                wgt_row   = 3'($urandom);
                cfg_rows  = 4'($urandom);
                win_sel   = 1'($urandom);
            end
            tick();
        end
        start     = 1'b0;
        wgt_we    = 1'b0;
        img_shift = 1'b0;
        img_up    = 1'b0;
        enable    = 1'b1;
        chk("busy_cycles", 64'(cnt), 64'(r + 1 + stall));
        chk("hold_acc8", acc8, e.e8);
        chk("hold_acc6", 64'(acc6), 64'(e.e6));
    endtask

    task automatic abort_run();
        start    = 1'b1;
        cfg_rows = 4'd7;
        win_sel  = 1'b0;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("abort_busy8", 64'(busy8), 64'd0);
        chk("abort_busy6", 64'(busy6), 64'd0);
        chk("abort_acc8", acc8, 64'd0);
        chk("abort_acc6", 64'(acc6), 64'd0);
        repeat (10) tick();
    endtask

    always @(negedge clk) begin
        if (ov8 === 1'b1 || ov6 === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=%b/%b, expected 0", ov8, ov6);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_valid_cycle", 64'(cyc), 64'(mon_e.due));
                chk("out_valid_pair", 64'({ov8, ov6}), 64'b11);
                chk("acc8", acc8, mon_e.e8);
                chk("acc6", 64'(acc6), 64'(mon_e.e6));
            end
        end
    end

    initial begin
        enable    = 1'b1;
        rst       = 1'b1;
        data_in   = '0;
        img_shift = 1'b0;
        img_up    = 1'b0;
        wgt_we    = 1'b0;
        wgt_ch    = '0;
        wgt_row   = '0;
        start     = 1'b0;
        cfg_rows  = '0;
        win_sel   = 1'b0;
        tick();
        do_reset();
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_ov8", 64'(ov8), 64'd0);
        chk("rst_acc8", acc8, 64'd0);
        chk("rst_busy6", 64'(busy6), 64'd0);
        chk("rst_ov6", 64'(ov6), 64'd0);
        chk("rst_acc6", 64'(acc6), 64'd0);

        // Full match on ch0, full mismatch on ch1.
        repeat (8) img_op(1'b1, 1'b0, 8'hFF);
        for (int r = 0; r < K; r++) begin
            wr(3'd0, 3'(r), 7'h7F);
            wr(3'd1, 3'(r), 7'h00);
            for (int c = 2; c < NCH; c++) wr(3'(c), 3'(r), 7'($urandom));
        end
        run_conv(7, 1'b0, 0, 1'b0);
        run_conv(3, 1'b0, 0, 1'b0);
        run_conv(0, 1'b1, 0, 1'b0);
        run_conv(12, 1'b0, 0, 1'b0);
        run_conv(7, 1'b0, 3, 1'b0);
        run_conv(7, 1'b0, 0, 1'b1);
        run_conv(5, 1'b1, 2, 1'b1);

        // Window select: every row 1000_0000, ch0 row0 = 100_0000.
        img_op(1'b1, 1'b0, 8'hFF);
        repeat (7) img_op(1'b1, 1'b0, 8'h00);
        wr(3'd0, 3'd0, 7'b100_0000);
        wr(3'd0, 3'd7, 7'h15);
        run_conv(1, 1'b1, 0, 1'b0);
        run_conv(1, 1'b0, 0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(1, 6)) begin
                if ($urandom_range(0, 2) == 0)
                    wr(3'($urandom), 3'($urandom), 7'($urandom));
                else
                    img_op(1'($urandom), 1'($urandom), 8'($urandom));
            end
            run_conv(int'($urandom_range(0, 15)), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                     1'($urandom));
        end

        abort_run();
        run_conv(7, 1'b0, 0, 1'b0);
        img_op(1'b1, 1'b1, 8'h5A);
        img_op(1'b0, 1'b1, 8'hFF);
        run_conv(7, 1'b1, 0, 1'b0);

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
